// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared encodings for the shared-ALU controller
package alu_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_logic_unit.sv
// rtl/alu_logic_unit.sv - combinational bitwise evaluator shared by both requesters
module alu_logic_unit
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = '0;
    case (alu_op_e'(op))
      OP_AND:  out = in0 & in1;
      OP_OR:   out = in0 | in1;
      OP_XOR:  out = in0 ^ in1;
      OP_NOR:  out = ~(in0 | in1);
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - two-requester arbiter in front of one shared bitwise ALU
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_in0,
  input  logic [WIDTH-1:0] req0_in1,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_in0,
  input  logic [WIDTH-1:0] req1_in1,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             busy,
  output logic [15:0]      done_count
);

  state_e           state;
  logic             ptr;
  logic             lat_id;
  logic [1:0]       lat_op;
  logic [WIDTH-1:0] lat_in0;
  logic [WIDTH-1:0] lat_in1;
  logic [WIDTH-1:0] alu_out;
  logic             grant0;
  logic             grant1;
  logic             hs0;
  logic             hs1;
  logic             rsp_hs;

  // ptr only breaks ties; a lone requester is always granted
  assign grant0 = req0_valid & (~req1_valid | ~ptr);
  assign grant1 = req1_valid & (~req0_valid | ptr);

  assign req0_ready = ~rst & (state == IDLE) & grant0;
  assign req1_ready = ~rst & (state == IDLE) & grant1;

  assign hs0    = req0_valid & req0_ready;
  assign hs1    = req1_valid & req1_ready;
  assign rsp_hs = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
  assign busy   = (state != IDLE);

  alu_logic_unit #(.WIDTH(WIDTH)) u_alu (
    .op  (lat_op),
    .in0 (lat_in0),
    .in1 (lat_in1),
    .out (alu_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      lat_id     <= 1'b0;
      lat_op     <= OP_AND;
      lat_in0    <= '0;
      lat_in1    <= '0;
      rsp_out    <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      done_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (hs0) begin
            lat_id  <= 1'b0;
            lat_op  <= req0_op;
            lat_in0 <= req0_in0;
            lat_in1 <= req0_in1;
            state   <= EXEC;
          end else if (hs1) begin
            lat_id  <= 1'b1;
            lat_op  <= req1_op;
            lat_in0 <= req1_in0;
            lat_in1 <= req1_in1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_out    <= alu_out;
          rsp0_valid <= ~lat_id;
          rsp1_valid <= lat_id;
          state      <= RESP;
        end
        RESP: begin
          // rsp_out is left holding the last result after completion
          if (rsp_hs) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            ptr        <= ~lat_id;
            done_count <= done_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - randomized and directed checks of alu_share_ctrl against a transaction model
module tb_alu_share_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_in0, req0_in1, req1_in0, req1_in1;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp_out;
  logic         busy;
  logic [15:0]  done_count;

  int checks = 0;
  int passes = 0;

  // transaction-level model: one pending job, its age in cycles, tie-break owner, counters
  bit           m_pend;
  bit           m_id;
  int           m_age;
  bit           m_ptr;
  logic [W-1:0] m_res;
  logic [W-1:0] m_out;
  logic [15:0]  m_cnt;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_in0(req0_in0), .req0_in1(req0_in1),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_in0(req1_in0), .req1_in1(req1_in1),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_out(rsp_out), .busy(busy), .done_count(done_count)
  );

  function automatic logic [W-1:0] calc(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] outs();
    return {11'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, done_count, rsp_out};
  endfunction

  task automatic model_reset();
    m_pend = 0; m_id = 0; m_age = 0; m_ptr = 0;
    m_res = '0; m_out = '0; m_cnt = '0;
  endtask

  task automatic set_req0(logic v, logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    req0_valid = v; req0_op = op; req0_in0 = a; req0_in1 = b;
  endtask

  task automatic set_req1(logic v, logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    req1_valid = v; req1_op = op; req1_in0 = a; req1_in1 = b;
  endtask

  // called at a negedge with inputs set: compare against model, then advance one edge
  task automatic step();
    logic e_r0, e_r1, e_v0, e_v1, e_busy, shown;
    logic [W-1:0] e_out;
    #1;
    shown  = m_pend && (m_age >= 1);
    e_r0   = !m_pend && req0_valid && (!req1_valid || !m_ptr);
    e_r1   = !m_pend && req1_valid && (!req0_valid || m_ptr);
    e_v0   = shown && !m_id;
    e_v1   = shown && m_id;
    e_busy = m_pend;
    e_out  = shown ? m_res : m_out;
    chk("cycle", outs(), {11'd0, e_r0, e_r1, e_v0, e_v1, e_busy, m_cnt, e_out});
    @(posedge clk);
    if (m_pend) begin
      if (m_age >= 1 && (m_id ? rsp1_ready : rsp0_ready)) begin
        m_pend = 0; m_ptr = !m_id; m_cnt = m_cnt + 16'd1; m_out = m_res;
      end else m_age++;
    end else if (e_r0) begin
      m_pend = 1; m_id = 0; m_age = 0; m_res = calc(req0_op, req0_in0, req0_in1);
    end else if (e_r1) begin
      m_pend = 1; m_id = 1; m_age = 0; m_res = calc(req1_op, req1_in0, req1_in1);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1 chk("reset_outputs", outs(), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    set_req0(1'b1, 2'd0, '0, '0);
    set_req1(1'b1, 2'd0, '0, '0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    do_reset();

    // single OR
    set_req1(1'b0, 2'd0, '0, '0);
    set_req0(1'b1, 2'b01, 32'h0000_F0F0, 32'h0F0F_0000);
    rsp0_ready = 1'b1;
    step();
    req0_valid = 1'b0;
    #1 chk("or_exec_no_valid", {rsp0_valid, busy}, 2'b01);
    step();
    #1 chk("or_rsp", {rsp0_valid, rsp_out}, {1'b1, 32'h0F0F_F0F0});
    step();
    #1 chk("or_count", {busy, done_count}, {1'b0, 16'd1});

    // contention from reset
    do_reset();
    set_req0(1'b1, 2'b00, 32'hFFFF_0000, 32'h00FF_FF00);
    set_req1(1'b1, 2'b10, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    step(); step();
    #1 chk("cont_first", {rsp0_valid, rsp1_valid, rsp_out}, {2'b10, 32'h00FF_0000});
    step();
    #1 chk("cont_alternate", {req0_ready, req1_ready}, 2'b01);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    #1 chk("cont_second", {rsp0_valid, rsp1_valid, rsp_out}, {2'b01, 32'h5555_5555});
    step();
    #1 chk("cont_count", done_count, 16'd2);

    // backpressure on requester 1
    set_req1(1'b1, 2'b10, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
    rsp1_ready = 1'b0;
    step();
    req1_valid = 1'b0; req0_valid = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_hold", {req0_ready, req1_ready, rsp1_valid, busy, rsp_out},
             {4'b0011, 32'h5555_5555});
      step();
    end
    rsp1_ready = 1'b1;
    step();
    req0_valid = 1'b0;
    #1 chk("bp_release_idle", {busy, rsp1_valid, done_count}, {2'b00, 16'd3});

    // operands change after acceptance
    set_req0(1'b1, 2'b11, 32'h0, 32'h0);
    rsp0_ready = 1'b0;
    step();
    set_req0(1'b0, 2'b00, 32'h1234_5678, 32'hFFFF_FFFF);
    step();
    #1 chk("late_operand", {rsp0_valid, rsp_out}, {1'b1, 32'hFFFF_FFFF});
    rsp0_ready = 1'b1;
    step();

    // reset asserted mid-EXEC
    set_req0(1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0000_1234);
    step();
    req0_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rst_mid_exec", outs(), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    set_req0(1'b1, 2'b01, 32'h1, 32'h2);
    step();
    req0_valid = 1'b0;
    step(); step();
    #1 chk("after_rst", {rsp_out, done_count}, {32'h3, 16'd1});

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      set_req0($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom);
      set_req1($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom);
      rsp0_ready = $urandom_range(0, 4) > 1;
      rsp1_ready = $urandom_range(0, 4) > 1;
      step();
    end

    // counter wrap
    set_req0(1'b0, 2'd0, '0, '0);
    set_req1(1'b0, 2'd0, '0, '0);
    do_reset();
    force dut.done_count = 16'hFFFF;
    #1 release dut.done_count;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    set_req1(1'b1, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00);
    rsp1_ready = 1'b1;
    step();
    req1_valid = 1'b0;
    step(); step();
    #1 chk("wrap", {rsp_out, done_count}, {32'hF000_F000, 16'h0000});
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
